bomb_controller: RTL and testbench

Upstream stage of box_top: owns the single bomb Bomberman can place. On a drop request it snaps Bomberman's position to the tile grid, runs a fuse countdown, then issues the one-cycle explosion_SCEN pulse with the explosion location e_x/e_y. It also holds the blast active for a display interval and drives per-pixel bomb/explosion "on" flags for the VGA mux.

---
 rtl/bomb_controller.sv | 141 ++++++++++++++
 tb/tb_bomb_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_controller.sv
// Single-bomb controller: snaps the drop position to the tile grid, runs the fuse,
// pulses explosion_SCEN on detonation and drives registered bomb/blast pixel flags.
module bomb_controller #(
   parameter int unsigned FUSE_TICKS  = 300000000,
   parameter int unsigned BLAST_TICKS = 50000000,
   parameter int unsigned TILE        = 16,
   parameter int unsigned GRID_X0     = 300,
   parameter int unsigned GRID_Y0     = 100,
   parameter int unsigned ARM_NEG     = 48,
   parameter int unsigned ARM_POS     = 63
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       drop,
   input  logic [9:0] b_x,
   input  logic [9:0] b_y,
   input  logic [9:0] v_x,
   input  logic [9:0] v_y,
   output logic [9:0] e_x,
   output logic [9:0] e_y,
   output logic       explosion_SCEN,
   output logic       bomb_on,
   output logic       explosion_on,
   output logic       busy
);

   localparam int unsigned MAX_TICKS = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
   localparam int unsigned CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam int unsigned LOG_TILE  = $clog2(TILE);
   localparam logic [CW-1:0] FUSE_LAST  = CW'(FUSE_TICKS - 1);
   localparam logic [CW-1:0] BLAST_LAST = CW'(BLAST_TICKS - 1);
   localparam logic [10:0] HALF_T  = 11'(TILE / 2);
   localparam logic [10:0] ORG_X   = 11'(GRID_X0);
   localparam logic [10:0] ORG_Y   = 11'(GRID_Y0);
   localparam logic signed [11:0] S_TILE_M1 = 12'(TILE - 1);
   localparam logic signed [11:0] S_NEG     = 12'(ARM_NEG);
   localparam logic signed [11:0] S_POS     = 12'(ARM_POS);

   typedef enum logic [1:0] {IDLE, ARMED, BLAST, REARM} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_drop_d;
   logic          w_rise, w_latch, w_scen_nxt;
   logic [9:0]    r_e_x, r_e_y;
   logic [9:0]    w_snap_x, w_snap_y;
   logic [10:0]   w_cx, w_cy, w_ox, w_oy;
   logic          r_scen, r_bomb_on, r_expl_on;
   logic signed [11:0] w_vx, w_vy, w_ex, w_ey;
   logic          w_in_col, w_in_row, w_in_harm, w_in_varm;

   assign w_rise = drop & ~r_drop_d;

   // Snap the sprite centre down to the tile grid; left/above the origin clamps to it.
   assign w_cx = {1'b0, b_x} + HALF_T;
   assign w_cy = {1'b0, b_y} + HALF_T;
   assign w_ox = w_cx - ORG_X;
   assign w_oy = w_cy - ORG_Y;
   assign w_snap_x = (w_cx < ORG_X) ? ORG_X[9:0] : 10'(ORG_X + ((w_ox >> LOG_TILE) << LOG_TILE));
   assign w_snap_y = (w_cy < ORG_Y) ? ORG_Y[9:0] : 10'(ORG_Y + ((w_oy >> LOG_TILE) << LOG_TILE));

   // Signed compares with one spare bit: a negative lower bound simply admits
   // every pixel (clamp at 0) and upper bounds past 1023 are not truncated.
   assign w_vx = $signed({2'b00, v_x});
   assign w_vy = $signed({2'b00, v_y});
   assign w_ex = $signed({2'b00, r_e_x});
   assign w_ey = $signed({2'b00, r_e_y});
   assign w_in_col  = (w_vx >= w_ex) && (w_vx <= w_ex + S_TILE_M1);
   assign w_in_row  = (w_vy >= w_ey) && (w_vy <= w_ey + S_TILE_M1);
   assign w_in_harm = (w_vx >= w_ex - S_NEG) && (w_vx <= w_ex + S_POS) && w_in_row;
   assign w_in_varm = (w_vy >= w_ey - S_NEG) && (w_vy <= w_ey + S_POS) && w_in_col;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_scen_nxt  = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_latch     = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (r_cnt == FUSE_LAST) begin
               w_cnt_nxt   = '0;
               w_scen_nxt  = 1'b1;
               w_state_nxt = BLAST;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         BLAST: begin
            if (r_cnt == BLAST_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = REARM;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         REARM: begin
            if (!drop) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_drop_d  <= 1'b0;
         r_e_x     <= '0;
         r_e_y     <= '0;
         r_scen    <= 1'b0;
         r_bomb_on <= 1'b0;
         r_expl_on <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_drop_d  <= drop;
         r_scen    <= w_scen_nxt;
         r_bomb_on <= (r_state == ARMED) && w_in_col && w_in_row;
         r_expl_on <= (r_state == BLAST) && (w_in_harm || w_in_varm);
         if (w_latch) begin
            r_e_x <= w_snap_x;
            r_e_y <= w_snap_y;
         end
      end
   end

   assign e_x            = r_e_x;
   assign e_y            = r_e_y;
   assign explosion_SCEN = r_scen;
   assign bomb_on        = r_bomb_on;
   assign explosion_on   = r_expl_on;
   assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller: timing derived from cycles since the drop,
// snap and pixel windows from plain integer arithmetic.
module tb_bomb_controller;

   localparam int FUSE  = 10;
   localparam int BLAST = 5;
   localparam int TILE  = 16;
   localparam int GX    = 300;
   localparam int GY    = 100;
   localparam int AN    = 48;
   localparam int AP    = 63;

   logic       clk = 1'b0;
   logic       reset, drop;
   logic [9:0] b_x, b_y, v_x, v_y, e_x, e_y;
   logic       scen, bomb_on, explosion_on, busy;

   int checks = 0;
   int errors = 0;
   int arm_q[$];
   int blast_q[$];

   always #5 clk = ~clk;

   bomb_controller #(.FUSE_TICKS(FUSE), .BLAST_TICKS(BLAST)) dut (
      .clk(clk), .reset(reset), .drop(drop),
      .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
      .e_x(e_x), .e_y(e_y), .explosion_SCEN(scen),
      .bomb_on(bomb_on), .explosion_on(explosion_on), .busy(busy)
   );

   function automatic int snap(input int b, input int org);
      int c;
      c = b + TILE / 2;
      if (c < org) return org;
      return (org + ((c - org) / TILE) * TILE) % 1024;
   endfunction

   function automatic bit in_tile(input int vx, input int vy, input int ex, input int ey);
      return (vx >= ex) && (vx <= ex + TILE - 1) && (vy >= ey) && (vy <= ey + TILE - 1);
   endfunction

   function automatic bit in_cross(input int vx, input int vy, input int ex, input int ey);
      int xlo, ylo;
      bit h, v;
      xlo = (ex - AN < 0) ? 0 : ex - AN;
      ylo = (ey - AN < 0) ? 0 : ey - AN;
      h = (vx >= xlo) && (vx <= ex + AP) && (vy >= ey) && (vy <= ey + TILE - 1);
      v = (vy >= ylo) && (vy <= ey + AP) && (vx >= ex) && (vx <= ex + TILE - 1);
      return h || v;
   endfunction

   task automatic wait_idle();
      drop = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_wait busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; drop = 1'b0;
      b_x = '0; b_y = '0; v_x = '0; v_y = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({e_x, e_y} !== 20'd0) begin
         errors++;
         $display("FAIL reset_exy got %0d,%0d required 0,0", e_x, e_y);
      end
      checks++;
      if ({scen, bomb_on, explosion_on, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b required 0000", {scen, bomb_on, explosion_on, busy});
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_busy got %b required 0", busy);
      end
   endtask

   // Drop at k=0; k counts clock edges since then. Busy until the first edge at or
   // after fuse+blast+2 that samples drop low.
   task automatic test_sequence(input int bx, input int by, input bit repulse, input int hold,
                                input string tag);
      int ex, ey;
      bit idle, d;
      wait_idle();
      ex = snap(bx, GX);
      ey = snap(by, GY);
      b_x = 10'(bx); b_y = 10'(by);
      drop = 1'b1;
      idle = 1'b0;
      for (int k = 1; k <= FUSE + BLAST + hold + 4; k++) begin
         d = drop;
         @(negedge clk);
         if (k >= FUSE + BLAST + 2 && d == 1'b0) idle = 1'b1;
         checks++;
         if (busy !== !idle) begin
            errors++;
            $display("FAIL %s busy k=%0d got %b required %b", tag, k, busy, !idle);
         end
         checks++;
         if (scen !== (k == FUSE + 1)) begin
            errors++;
            $display("FAIL %s scen k=%0d got %b required %b", tag, k, scen, (k == FUSE + 1));
         end
         checks++;
         if (e_x !== 10'(ex) || e_y !== 10'(ey)) begin
            errors++;
            $display("FAIL %s exy k=%0d got %0d,%0d required %0d,%0d", tag, k, e_x, e_y, ex, ey);
         end
         if (idle) break;
         if (repulse) begin
            b_x = 10'($urandom_range(0, 1023));
            b_y = 10'($urandom_range(0, 1023));
         end
         if (k < FUSE + BLAST) drop = repulse ? 1'($urandom_range(0, 1)) : (k < 2);
         else drop = (k < FUSE + BLAST + hold);
      end
      if (!idle) begin
         checks++;
         errors++;
         $display("FAIL %s return_to_idle not reached within bound", tag);
      end
   endtask

   task automatic test_snap();
      test_sequence(290, 90, 1'b0, 0, "snap_clamp");
      test_sequence(323, 100, 1'b0, 0, "snap_323");
      test_sequence(324, 100, 1'b0, 0, "snap_324");
      for (int i = 0; i < 6; i++)
         test_sequence(int'($urandom_range(0, 1023)), int'($urandom_range(0, 900)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "snap_rand");
   endtask

   // Flags seen at edge k reflect the phase and pixel of the interval before it.
   task automatic test_pixels(input int bx, input int by, input string tag);
      int ex, ey, pk, pvx, pvy, vx, vy, i;
      bit exp_b, exp_e;
      wait_idle();
      ex = snap(bx, GX);
      ey = snap(by, GY);
      b_x = 10'(bx); b_y = 10'(by);
      v_x = 10'(ex); v_y = 10'(ey);
      pvx = ex; pvy = ey;
      drop = 1'b1;
      for (int k = 1; k <= FUSE + BLAST + 2; k++) begin
         @(negedge clk);
         pk = k - 1;
         exp_b = (pk >= 1 && pk <= FUSE) && in_tile(pvx, pvy, ex, ey);
         exp_e = (pk >= FUSE + 1 && pk <= FUSE + BLAST) && in_cross(pvx, pvy, ex, ey);
         checks++;
         if (bomb_on !== exp_b) begin
            errors++;
            $display("FAIL %s bomb_on v=(%0d,%0d) got %b required %b", tag, pvx, pvy, bomb_on, exp_b);
         end
         checks++;
         if (explosion_on !== exp_e) begin
            errors++;
            $display("FAIL %s explosion_on v=(%0d,%0d) got %b required %b", tag, pvx, pvy, explosion_on, exp_e);
         end
         checks++;
         if ((bomb_on & explosion_on) !== 1'b0) begin
            errors++;
            $display("FAIL %s flags_exclusive got both set required not both", tag);
         end
         drop = 1'b0;
         vx = ex - 70 + int'($urandom_range(0, 160));
         vy = ey - 70 + int'($urandom_range(0, 160));
         if (vx < 0) vx = 0;
         if (vx > 1023) vx = 1023;
         if (vy < 0) vy = 0;
         if (vy > 1023) vy = 1023;
         if (k >= 1 && k <= FUSE) begin
            i = k - 1;
            if (i < arm_q.size()) begin vx = arm_q[i] / 1024; vy = arm_q[i] % 1024; end
         end else if (k >= FUSE + 1 && k <= FUSE + BLAST) begin
            i = k - FUSE - 1;
            if (i < blast_q.size()) begin vx = blast_q[i] / 1024; vy = blast_q[i] % 1024; end
         end
         v_x = 10'(vx); v_y = 10'(vy);
         pvx = vx; pvy = vy;
      end
   endtask

   task automatic test_pixel_windows();
      arm_q.delete(); blast_q.delete();
      arm_q.push_back(316 * 1024 + 100);
      arm_q.push_back(331 * 1024 + 115);
      arm_q.push_back(332 * 1024 + 100);
      blast_q.push_back(268 * 1024 + 100);
      blast_q.push_back(379 * 1024 + 115);
      blast_q.push_back(267 * 1024 + 100);
      blast_q.push_back(316 * 1024 + 52);
      test_pixels(310, 105, "pix_316");
      arm_q.delete(); blast_q.delete();
      blast_q.push_back(0 * 1024 + 100);
      blast_q.push_back(252 * 1024 + 100);
      test_pixels(290, 90, "pix_300");
      arm_q.delete(); blast_q.delete();
      for (int n = 0; n < 3; n++)
         test_pixels(int'($urandom_range(250, 1023)), int'($urandom_range(60, 900)), "pix_rand");
   endtask

   task automatic test_reset_abort();
      wait_idle();
      b_x = 10'($urandom_range(300, 700)); b_y = 10'($urandom_range(100, 400));
      drop = 1'b1;
      for (int k = 1; k <= FUSE - 2; k++) begin
         @(negedge clk);
         drop = 1'b0;
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({e_x, e_y, scen, bomb_on, explosion_on, busy} !== 24'd0) begin
         errors++;
         $display("FAIL abort_reset_outputs got %0d,%0d,%b required all zero",
                  e_x, e_y, {scen, bomb_on, explosion_on, busy});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 2 * FUSE; k++) begin
         @(negedge clk);
         checks++;
         if (scen !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_scen k=%0d got scen=%b busy=%b required 0,0", k, scen, busy);
         end
      end
      test_sequence(int'($urandom_range(300, 700)), int'($urandom_range(100, 400)), 1'b0, 1, "after_abort");
   endtask

   initial begin
      test_reset();
      test_sequence(310, 105, 1'b0, 0, "basic");
      test_sequence(310, 105, 1'b1, 3, "repulse_hold");
      test_snap();
      test_pixel_windows();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
